// File: rtl/conv_enc_frame.sv
// conv_enc_frame -- frame-based rate-1/2 convolutional encoder.
//
// Takes FRAME_LEN information bits over a valid/ready handshake. It emits one
// 2-bit coded symbol per accepted bit, one cycle after acceptance. After the
// last bit it appends FLUSH_LEN zero-input symbols back-to-back. The flush
// terminates the trellis and drains the downstream Viterbi traceback.
//
// Ports
//   clk           in   clock, rising edge
//   RSTn          in   asynchronous active-low reset
//   bit_in_valid  in   upstream bit valid
//   bit_in        in   information bit
//   err_mask[1:0] in   (CONV_ENC_ERR_INJ_EN only) XORed into the emitted symbol
//   bit_in_ready  out  encoder accepts a bit this cycle (registered)
//   d_out_valid   out  coded symbol valid (drives decoder d_in_valid)
//   d_out[1:0]    out  [0]=G0 parity (first on channel), [1]=G1 parity
//   frame_done    out  one-cycle pulse alongside the last flush symbol
//
// Optional feature macro: CONV_ENC_ERR_INJ_EN (adds err_mask for BER testing).
// All outputs are registers; there is no combinational input-to-output path.

module conv_enc_frame #(
   parameter int             K         = 7,
   parameter logic [K-1:0]   G0        = 7'b1111001,
   parameter logic [K-1:0]   G1        = 7'b1011011,
   parameter int             FRAME_LEN = 512,
   parameter int             FLUSH_LEN = 32
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       bit_in_valid,
   input  logic       bit_in,
`ifdef CONV_ENC_ERR_INJ_EN
   input  logic [1:0] err_mask,
`endif
   output logic       bit_in_ready,
   output logic       d_out_valid,
   output logic [1:0] d_out,
   output logic       frame_done
);

   localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_LEN - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

   // A flush shorter than the memory would leave the trellis unterminated.
   generate
      if (FLUSH_LEN < K - 1) begin : g_bad_flush
         $error("conv_enc_frame: FLUSH_LEN must be >= K-1");
      end
   endgenerate

   typedef enum logic {DATA = 1'b0, FLUSH = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [K-2:0]  sreg, sreg_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic [FW-1:0] flush_cnt, flush_cnt_nxt;
   logic [1:0]    d_out_nxt;
   logic          valid_nxt, done_nxt, ready_nxt;

   logic          accept, u;
   logic [K-1:0]  r;
   logic [1:0]    par, inj;

`ifdef CONV_ENC_ERR_INJ_EN
   assign inj = err_mask;
`else
   assign inj = 2'b00;
`endif

   // Encoding register: newest bit at the MSB, older bits below it.
   assign accept = (state == DATA) && bit_in_valid && bit_in_ready;
   assign u      = (state == DATA) ? bit_in : 1'b0;
   assign r      = {u, sreg};
   assign par    = {^(r & G1), ^(r & G0)};

   always_comb begin
      state_nxt     = state;
      sreg_nxt      = sreg;
      bit_cnt_nxt   = bit_cnt;
      flush_cnt_nxt = flush_cnt;
      d_out_nxt     = d_out;        // d_out holds when no symbol is produced
      valid_nxt     = 1'b0;
      done_nxt      = 1'b0;
      case (state)
         DATA: begin
            if (accept) begin
               sreg_nxt  = r[K-1:1];
               d_out_nxt = par ^ inj;
               valid_nxt = 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = FLUSH;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         FLUSH: begin
            // Unconditional: the decoder cannot stall us.
            sreg_nxt  = r[K-1:1];
            d_out_nxt = par ^ inj;
            valid_nxt = 1'b1;
            if (flush_cnt == FLUSH_LAST) begin
               done_nxt      = 1'b1;
               flush_cnt_nxt = '0;
               state_nxt     = DATA;
            end else begin
               flush_cnt_nxt = flush_cnt + 1'b1;
            end
         end
         default: state_nxt = DATA;
      endcase
      // Drops on the edge that takes the last bit. It rises one edge after
      // returning to DATA, which leaves one idle output cycle between frames.
      ready_nxt = (state == DATA) && (state_nxt == DATA);
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state        <= DATA;
         sreg         <= '0;
         bit_cnt      <= '0;
         flush_cnt    <= '0;
         d_out        <= 2'b00;
         d_out_valid  <= 1'b0;
         frame_done   <= 1'b0;
         bit_in_ready <= 1'b0;
      end else begin
         state        <= state_nxt;
         sreg         <= sreg_nxt;
         bit_cnt      <= bit_cnt_nxt;
         flush_cnt    <= flush_cnt_nxt;
         d_out        <= d_out_nxt;
         d_out_valid  <= valid_nxt;
         frame_done   <= done_nxt;
         bit_in_ready <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_conv_enc_frame.sv
// Self-checking bench for conv_enc_frame (default parameters).
// The reference encoder is a direct convolution of the frame's input
// sequence (data bits followed by zero flush bits) with the octal generators.

module tb_conv_enc_frame;

   localparam int K         = 7;
   localparam int FRAME_LEN = 512;
   localparam int FLUSH_LEN = 32;
   localparam int SYMS      = FRAME_LEN + FLUSH_LEN;

   logic       clk = 1'b0;
   logic       RSTn = 1'b1;
   logic       bit_in_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_in_ready, d_out_valid, frame_done;
   logic [1:0] d_out;
`ifdef CONV_ENC_ERR_INJ_EN
   logic [1:0] err_mask = 2'b00;
`endif

   conv_enc_frame dut (
      .clk(clk), .RSTn(RSTn), .bit_in_valid(bit_in_valid), .bit_in(bit_in),
`ifdef CONV_ENC_ERR_INJ_EN
      .err_mask(err_mask),
`endif
      .bit_in_ready(bit_in_ready), .d_out_valid(d_out_valid),
      .d_out(d_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;
   bit         src_q[$];
   logic [1:0] sym_q[$];
   logic [1:0] exp_q[$];
   bit         done_q[$], rdy_q[$];
   int         cyc_q[$], acc_q[$];
   int         inj_idx = -1;
   bit         timed_out;

   // Expected symbols: frames taken from src_q, each starting from zero state.
   task automatic build_exp(input int nframes);
      logic [K-1:0] g0, g1;
      bit seq[$];
      bit p0, p1;
      g0 = 7'o171;
      g1 = 7'o133;
      exp_q.delete();
      for (int f = 0; f < nframes; f++) begin
         seq.delete();
         for (int i = 0; i < FRAME_LEN; i++) seq.push_back(src_q[f*FRAME_LEN + i]);
         for (int i = 0; i < FLUSH_LEN; i++) seq.push_back(1'b0);
         for (int n = 0; n < SYMS; n++) begin
            p0 = 1'b0; p1 = 1'b0;
            for (int j = 0; j < K; j++)
               if (n - j >= 0) begin
                  p0 ^= seq[n-j] & g0[K-1-j];
                  p1 ^= seq[n-j] & g1[K-1-j];
               end
            exp_q.push_back({p1, p0});
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      RSTn = 1'b0;
      bit_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
   endtask

   // Feeds src_q (gap=1: valid only on alternate cycles), records every valid
   // symbol seen at the falling edge. Stops after `tail` idle cycles once the
   // source is exhausted, or as soon as stop_at bits have been accepted.
   task automatic drive(input int gap, input int tail, input int stop_at);
      int idx = 0, c = 0, t = 0;
      bit acc = 1'b0, fin = 1'b0;
      sym_q.delete(); done_q.delete(); rdy_q.delete(); cyc_q.delete(); acc_q.delete();
      timed_out = 1'b0;
      while (!fin) begin
         @(negedge clk);
         if (d_out_valid) begin
            sym_q.push_back(d_out); done_q.push_back(frame_done);
            rdy_q.push_back(bit_in_ready); cyc_q.push_back(c);
         end
         if (acc) idx++;
         if (stop_at >= 0 && idx >= stop_at) begin
            bit_in_valid = 1'b0;
            fin = 1'b1;
         end else begin
            if (idx >= src_q.size()) begin
               bit_in_valid = 1'b0;
               t++;
               if (t >= tail) fin = 1'b1;
            end else begin
               bit_in_valid = (gap == 0) ? 1'b1 : (c % 2 == 0);
               bit_in = src_q[idx];
            end
`ifdef CONV_ENC_ERR_INJ_EN
            err_mask = (inj_idx >= 0 && idx == inj_idx && bit_in_valid) ? 2'b01 : 2'b00;
`endif
            acc = bit_in_valid && bit_in_ready;
            if (acc) acc_q.push_back(c);
         end
         c++;
         if (c > 20000) begin timed_out = 1'b1; fin = 1'b1; bit_in_valid = 1'b0; end
      end
   endtask

   task automatic test_reset();
      #3 RSTn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({bit_in_ready, d_out_valid, d_out, frame_done} !== 5'b0) $display("FAIL reset_hold: got %b want 00000", {bit_in_ready, d_out_valid, d_out, frame_done}); else passes++;
      RSTn = 1'b1;
      #1;
      checks++; if (bit_in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", bit_in_ready); else passes++;
      @(negedge clk);
      checks++; if (bit_in_ready !== 1'b1) $display("FAIL ready_first_edge: got %b want 1", bit_in_ready); else passes++;
      repeat (4) begin
         checks++;
         if ({d_out_valid, d_out, frame_done} !== 4'b0) $display("FAIL idle_outputs: got %b want 0000", {d_out_valid, d_out, frame_done}); else passes++;
         @(negedge clk);
      end
   endtask

   task automatic check_impulse(input string tag);
      logic [1:0] imp [10];
      imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
      src_q = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      drive(0, 3, -1);
      checks++; if (sym_q.size() != 10) $display("FAIL %s_count: got %0d want 10", tag, sym_q.size()); else passes++;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (k >= sym_q.size() || sym_q[k] !== imp[k])
            $display("FAIL %s_sym%0d: got %b want %b", tag, k, (k < sym_q.size()) ? sym_q[k] : 2'bxx, imp[k]);
         else passes++;
      end
   endtask

   task automatic test_impulse();
      apply_reset();
      check_impulse("impulse");
   endtask

   bit frame1[$];
   logic [1:0] exp1[$];

   task automatic test_full_frame();
      apply_reset();
      src_q.delete();
      for (int i = 0; i < FRAME_LEN; i++) src_q.push_back(1'($urandom_range(1)));
      frame1 = src_q;
      build_exp(1);
      exp1 = exp_q;
      drive(0, 40, -1);
      checks++; if (timed_out || sym_q.size() != SYMS) $display("FAIL full_count: got %0d want %0d", sym_q.size(), SYMS); else passes++;
      checks++; if (sym_q.size() == SYMS && cyc_q[SYMS-1] - cyc_q[0] != SYMS-1) $display("FAIL full_gapless: span %0d want %0d", cyc_q[SYMS-1] - cyc_q[0], SYMS-1); else passes++;
      for (int k = 0; k < SYMS; k++) begin
         logic [1:0] a;
         bit d, rd;
         a  = (k < sym_q.size()) ? sym_q[k] : 2'bxx;
         d  = (k < done_q.size()) ? done_q[k] : 1'b0;
         rd = (k < rdy_q.size()) ? rdy_q[k] : 1'b0;
         checks++; if (a !== exp1[k]) $display("FAIL full_sym%0d: got %b want %b", k, a, exp1[k]); else passes++;
         checks++; if (d !== (k == SYMS-1)) $display("FAIL full_done%0d: got %b want %b", k, d, (k == SYMS-1)); else passes++;
         // ready is low from the edge that accepts the last data bit
         checks++; if (rd !== (k < FRAME_LEN-1)) $display("FAIL full_ready%0d: got %b want %b", k, rd, (k < FRAME_LEN-1)); else passes++;
      end
   endtask

   task automatic test_gaps();
      apply_reset();
      src_q = frame1;
      drive(1, 40, -1);
      checks++; if (timed_out || sym_q.size() != SYMS) $display("FAIL gap_count: got %0d want %0d", sym_q.size(), SYMS); else passes++;
      for (int k = 0; k < SYMS; k++) begin
         checks++;
         if (k >= sym_q.size() || sym_q[k] !== exp1[k])
            $display("FAIL gap_sym%0d: got %b want %b", k, (k < sym_q.size()) ? sym_q[k] : 2'bxx, exp1[k]);
         else passes++;
      end
      for (int k = 0; k < FRAME_LEN; k++) begin
         checks++;
         if (k >= cyc_q.size() || k >= acc_q.size() || cyc_q[k] != acc_q[k] + 1)
            $display("FAIL gap_latency%0d: symbol cycle %0d accept cycle %0d", k,
                     (k < cyc_q.size()) ? cyc_q[k] : -1, (k < acc_q.size()) ? acc_q[k] : -1);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      apply_reset();
      src_q.delete();
      for (int i = 0; i < 2*FRAME_LEN; i++) src_q.push_back(1'($urandom_range(1)));
      build_exp(2);
      drive(0, 40, -1);
      checks++; if (timed_out || sym_q.size() != 2*SYMS) $display("FAIL b2b_count: got %0d want %0d", sym_q.size(), 2*SYMS); else passes++;
      checks++; if (sym_q.size() != 2*SYMS || cyc_q[SYMS] - cyc_q[SYMS-1] != 2) $display("FAIL b2b_idle_gap: got %0d want 2", (sym_q.size() == 2*SYMS) ? cyc_q[SYMS] - cyc_q[SYMS-1] : -1); else passes++;
      for (int k = 0; k < 2*SYMS; k++) begin
         checks++;
         if (k >= sym_q.size() || sym_q[k] !== exp_q[k])
            $display("FAIL b2b_sym%0d: got %b want %b", k, (k < sym_q.size()) ? sym_q[k] : 2'bxx, exp_q[k]);
         else passes++;
         if (k < done_q.size() && done_q[k]) ndone++;
      end
      checks++; if (ndone != 2 || done_q.size() != 2*SYMS || !done_q[2*SYMS-1]) $display("FAIL b2b_done: got %0d pulses want 2 at frame ends", ndone); else passes++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      src_q.delete();
      for (int i = 0; i < FRAME_LEN; i++) src_q.push_back(1'($urandom_range(1)));
      drive(0, 0, 200);
      checks++; if (sym_q.size() != 200 || d_out_valid !== 1'b1) $display("FAIL mid_pre: got %0d symbols valid=%b want 200 valid=1", sym_q.size(), d_out_valid); else passes++;
      #2 RSTn = 1'b0;
      #1;
      checks++; if ({bit_in_ready, d_out_valid, d_out, frame_done} !== 5'b0) $display("FAIL mid_async: got %b want 00000", {bit_in_ready, d_out_valid, d_out, frame_done}); else passes++;
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
      check_impulse("mid_impulse");
   endtask

`ifdef CONV_ENC_ERR_INJ_EN
   task automatic test_err_inj();
      int ndone = 0;
      apply_reset();
      src_q.delete();
      for (int i = 0; i < FRAME_LEN; i++) src_q.push_back(1'b0);
      inj_idx = 9;
      drive(0, 40, -1);
      inj_idx = -1;
      checks++; if (sym_q.size() != SYMS) $display("FAIL inj_count: got %0d want %0d", sym_q.size(), SYMS); else passes++;
      for (int k = 0; k < SYMS; k++) begin
         logic [1:0] w;
         w = (k == 9) ? 2'b01 : 2'b00;
         checks++;
         if (k >= sym_q.size() || sym_q[k] !== w)
            $display("FAIL inj_sym%0d: got %b want %b", k, (k < sym_q.size()) ? sym_q[k] : 2'bxx, w);
         else passes++;
         if (k < done_q.size() && done_q[k]) ndone++;
      end
      checks++; if (ndone != 1 || done_q.size() != SYMS || !done_q[SYMS-1]) $display("FAIL inj_done: got %0d pulses want 1 on last symbol", ndone); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_impulse();
      test_full_frame();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
`ifdef CONV_ENC_ERR_INJ_EN
      test_err_inj();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
